// File: rtl/uart_fifo_tx.sv
// UART transmitter fed from a FIFO: pops one byte, frames it as start/8 data/
// [parity]/stop and shifts it out LSB first. Back-to-back frames when enabled.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit.
module uart_fifo_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Tx_En,
    input  logic [7:0] Fifo_Data,
    input  logic [3:0] Fifo_Status,
    output logic       Fifo_Read,
    output logic       Tx,
    output logic       Busy,
    output logic       Tx_Done
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 3;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    bit_cnt, bit_cnt_n;
    logic [IDX_W-1:0]    bit_idx, bit_idx_n;
    logic                stop_idx, stop_idx_n;
    logic [DATA_W-1:0]   shift_reg, shift_reg_n;
    logic                tx_n, busy_n, read_n, done_n;
    logic                fifo_empty;
    logic                bit_end;
    logic                unused_status;
`ifdef UART_TX_PARITY_EN
    logic                parity_bit, parity_bit_n;
`endif

    // Only the empty flag matters; the other FIFO flags are deliberately ignored.
    assign fifo_empty    = Fifo_Status[0];
    assign unused_status = ^Fifo_Status[3:1];
    assign bit_end       = (bit_cnt == CNT_LAST);

    // Next-state logic; outputs are derived from next-state values so the
    // registered outputs line up with the state they describe.
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        bit_idx_n   = bit_idx;
        stop_idx_n  = stop_idx;
        shift_reg_n = shift_reg;
`ifdef UART_TX_PARITY_EN
        parity_bit_n = parity_bit;
`endif

        case (state)
            IDLE: begin
                if (Tx_En && !fifo_empty) state_n = FETCH;
            end
            FETCH: begin
                state_n = LOAD;
            end
            LOAD: begin
                shift_reg_n = Fifo_Data;
`ifdef UART_TX_PARITY_EN
                parity_bit_n = ^Fifo_Data;
`endif
                bit_cnt_n   = '0;
                state_n     = START;
            end
            START: begin
                if (bit_end) begin
                    bit_cnt_n = '0;
                    bit_idx_n = '0;
                    state_n   = DATA;
                end else begin
                    bit_cnt_n = bit_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_cnt_n   = '0;
                    shift_reg_n = {1'b0, shift_reg[DATA_W-1:1]};
                    if (bit_idx == IDX_LAST) begin
                        bit_idx_n  = '0;
                        stop_idx_n = 1'b0;
`ifdef UART_TX_PARITY_EN
                        state_n    = PARITY;
`else
                        state_n    = STOP;
`endif
                    end else begin
                        bit_idx_n = bit_idx + IDX_W'(1);
                    end
                end else begin
                    bit_cnt_n = bit_cnt + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    bit_cnt_n  = '0;
                    stop_idx_n = 1'b0;
                    state_n    = STOP;
                end else begin
                    bit_cnt_n = bit_cnt + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    bit_cnt_n = '0;
                    if (stop_idx == STOP_LAST) begin
                        stop_idx_n = 1'b0;
                        state_n    = (Tx_En && !fifo_empty) ? FETCH : IDLE;
                    end else begin
                        stop_idx_n = stop_idx + 1'b1;
                    end
                end else begin
                    bit_cnt_n = bit_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        tx_n = 1'b1;
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_reg_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_n = parity_bit_n;
`endif
            default: tx_n = 1'b1;
        endcase

        busy_n = (state_n != IDLE);
        read_n = (state_n == FETCH);
        done_n = (state_n == STOP) && (bit_cnt_n == CNT_LAST) && (stop_idx_n == STOP_LAST);
    end

    // State, datapath and output registers; reset forces the idle line at once.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            shift_reg <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
            Tx        <= 1'b1;
            Busy      <= 1'b0;
            Fifo_Read <= 1'b0;
            Tx_Done   <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            bit_idx   <= bit_idx_n;
            stop_idx  <= stop_idx_n;
            shift_reg <= shift_reg_n;
`ifdef UART_TX_PARITY_EN
            parity_bit <= parity_bit_n;
`endif
            Tx        <= tx_n;
            Busy      <= busy_n;
            Fifo_Read <= read_n;
            Tx_Done   <= done_n;
        end
    end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Self-checking bench for uart_fifo_tx: a FIFO model feeds bytes, a scoreboard
// holds expected bytes, and each serial frame is checked cycle by cycle.
module tb_uart_fifo_tx;

    localparam int unsigned CPB       = 4;
    localparam int unsigned STOP_BITS = 1;
    localparam int          TIMEOUT   = 400;

    logic       Clk;
    logic       Reset;
    logic       Tx_En;
    logic [7:0] Fifo_Data;
    logic [3:0] Fifo_Status;
    logic       Fifo_Read;
    logic       Tx;
    logic       Busy;
    logic       Tx_Done;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_reads = 0;
    bit         hold_data;
    logic       s_tx, s_busy, s_done, s_rd;

    uart_fifo_tx #(
        .CLKS_PER_BIT (CPB),
        .STOP_BITS    (STOP_BITS)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Tx_En       (Tx_En),
        .Fifo_Data   (Fifo_Data),
        .Fifo_Status (Fifo_Status),
        .Fifo_Read   (Fifo_Read),
        .Tx          (Tx),
        .Busy        (Busy),
        .Tx_Done     (Tx_Done)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Empty flag follows the model; the unused flag bits are randomised.
    task automatic refresh_fifo();
        Fifo_Status = {3'($urandom_range(0, 7)), (fifo_q.size() == 0)};
    endtask

    // One clock: sample outputs on the falling edge, then service the FIFO.
    // Popped data is presented for FETCH and LOAD, then scrambled.
    task automatic step();
        @(negedge Clk);
        s_tx   = Tx;
        s_busy = Busy;
        s_done = Tx_Done;
        s_rd   = Fifo_Read;
        if (s_rd) begin
            n_reads++;
            if (fifo_q.size() > 0) Fifo_Data = fifo_q.pop_front();
            hold_data = 1'b1;
        end else if (hold_data) begin
            hold_data = 1'b0;
        end else begin
            Fifo_Data = 8'($urandom);
        end
        refresh_fifo();
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        exp_q.push_back(b);
        refresh_fifo();
    endtask

    task automatic wait_start(output bit found, output int gap);
        found = 1'b0;
        gap   = 0;
        for (int t = 0; t < TIMEOUT; t++) begin
            step();
            if (s_tx == 1'b0) begin
                found = 1'b1;
                break;
            end
            gap++;
        end
    endtask

    task automatic check_frame(input string tag, input bit drop_en, output int gap);
        logic [7:0]  b;
        logic [15:0] frame;
        logic [31:0] obs, want;
        int          nb, done_cnt, busy_low;
        bit          done_last, found;
        wait_start(found, gap);
        check({tag, "_start_seen"}, 32'(found), 32'd1);
        if (!found) return;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_underflow"}, 32'd1, 32'd0);
            return;
        end
        b = exp_q.pop_front();
        frame    = '0;
        frame[0] = 1'b0;
        for (int i = 0; i < 8; i++) frame[1+i] = b[i];
        nb = 9;
`ifdef UART_TX_PARITY_EN
        frame[9] = ^b;
        nb = 10;
`endif
        for (int s = 0; s < int'(STOP_BITS); s++) begin
            frame[nb] = 1'b1;
            nb++;
        end
        if (drop_en) Tx_En = 1'b0;
        done_cnt  = 0;
        busy_low  = 0;
        done_last = 1'b0;
        for (int i = 0; i < nb; i++) begin
            obs = '0;
            for (int c = 0; c < int'(CPB); c++) begin
                if (i != 0 || c != 0) step();
                obs[c] = s_tx;
                if (s_done) begin
                    done_cnt++;
                    if (i == nb - 1 && c == int'(CPB) - 1) done_last = 1'b1;
                end
                if (!s_busy) busy_low++;
            end
            want = frame[i] ? 32'((64'd1 << CPB) - 64'd1) : 32'd0;
            check($sformatf("%s_%02x_bit%0d", tag, b, i), obs, want);
        end
        check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        check({tag, "_done_last"}, 32'(done_last), 32'd1);
        check({tag, "_busy_low"}, 32'(busy_low), 32'd0);
    endtask

    initial begin
        int         gap, r0, rd_cnt, tx_low, busy_hi;
        bit         found;
        logic [7:0] junk;

        Reset     = 1'b1;
        Tx_En     = 1'b0;
        Fifo_Data = 8'h00;
        hold_data = 1'b0;
        refresh_fifo();
        repeat (3) step();
        check("rst_tx",   32'(s_tx),   32'd1);
        check("rst_busy", 32'(s_busy), 32'd0);
        check("rst_read", 32'(s_rd),   32'd0);
        check("rst_done", 32'(s_done), 32'd0);
        Reset = 1'b0;

        // Single byte 0xA5, then return to idle with an empty FIFO.
        push(8'hA5);
        Tx_En = 1'b1;
        r0 = n_reads;
        check_frame("a5", 1'b0, gap);
        repeat (6) step();
        check("a5_reads",     32'(n_reads - r0), 32'd1);
        check("a5_idle_busy", 32'(s_busy), 32'd0);
        check("a5_idle_tx",   32'(s_tx),   32'd1);

        // Back-to-back bytes: two idle-high cycles between frames.
        Tx_En = 1'b0;
        push(8'h3C);
        push(8'h81);
        push(8'h07);
        r0 = n_reads;
        Tx_En = 1'b1;
        check_frame("b2b0", 1'b0, gap);
        check_frame("b2b1", 1'b0, gap);
        check("b2b1_gap", 32'(gap), 32'd2);
        check_frame("b2b2", 1'b0, gap);
        check("b2b2_gap", 32'(gap), 32'd2);
        repeat (6) step();
        check("b2b_reads", 32'(n_reads - r0), 32'd3);

        // Empty FIFO with enable held: nothing must happen for 100 cycles.
        rd_cnt = 0; tx_low = 0; busy_hi = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (s_rd)   rd_cnt++;
            if (!s_tx)  tx_low++;
            if (s_busy) busy_hi++;
        end
        check("empty_reads",   32'(rd_cnt),  32'd0);
        check("empty_tx_low",  32'(tx_low),  32'd0);
        check("empty_busy_hi", 32'(busy_hi), 32'd0);

        // Reset in the middle of data bit 3, between clock edges.
        push(8'h52);
        wait_start(found, gap);
        check("rst_mid_start_seen", 32'(found), 32'd1);
        repeat (17) step();
        check("pre_rst_bit3", 32'(s_tx),   32'd0);
        check("pre_rst_busy", 32'(s_busy), 32'd1);
        #1 Reset = 1'b1;
        #1;
        check("rst_mid_tx",   32'(Tx),        32'd1);
        check("rst_mid_busy", 32'(Busy),      32'd0);
        check("rst_mid_read", 32'(Fifo_Read), 32'd0);
        check("rst_mid_done", 32'(Tx_Done),   32'd0);
        junk = exp_q.pop_front();
        hold_data = 1'b0;
        repeat (3) step();
        check("rst_hold_busy", 32'(s_busy), 32'd0);
        push(8'h96);
        r0 = n_reads;
        Reset = 1'b0;
        #1;
        check("rst_release_read", 32'(Fifo_Read), 32'd0);
        check_frame("post_rst", 1'b0, gap);
        check("post_rst_gap", 32'(gap), 32'd2);
        repeat (4) step();
        check("post_rst_reads", 32'(n_reads - r0), 32'd1);

        // Enable dropped during START: frame completes, no further pops.
        push(8'hC3);
        push(8'h5E);
        r0 = n_reads;
        check_frame("drop", 1'b1, gap);
        busy_hi = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (s_busy) busy_hi++;
        end
        check("drop_reads",   32'(n_reads - r0), 32'd1);
        check("drop_busy_hi", 32'(busy_hi), 32'd0);
        check("drop_fifo_left", 32'(fifo_q.size()), 32'd1);
        Tx_En = 1'b1;
        check_frame("drain", 1'b0, gap);

        // A few random bytes streamed back to back.
        for (int k = 0; k < 3; k++) push(8'($urandom));
        for (int k = 0; k < 3; k++) begin
            check_frame($sformatf("rnd%0d", k), 1'b0, gap);
            if (k > 0) check($sformatf("rnd%0d_gap", k), 32'(gap), 32'd2);
        end
        repeat (6) step();
        check("sb_empty_at_end", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_fifo_tx.md
UART_FIFO_TX -- requirements
Module: uart_fifo_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, giving the Clk cycles per serial bit; legal values are 2..65535.
REQ-002 The block SHALL have parameter STOP_BITS, default 1, giving the number of stop bits per frame; legal values are 1 or 2.
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port Tx_En, input, 1 bit: permits a new frame to start.
REQ-006 The block SHALL have port Fifo_Data, input, 8 bits: byte supplied by the transmit FIFO.
REQ-007 The block SHALL have port Fifo_Status, input, 4 bits: FIFO flags; bit0 is empty, bit1 full, bit2 almost-full, bit3 almost-empty; only bit0 is used.
REQ-008 The block SHALL have port Fifo_Read, output, 1 bit: one-cycle pop strobe to the FIFO.
REQ-009 The block SHALL have port Tx, output, 1 bit: the serial line, idle high.
REQ-010 The block SHALL have port Busy, output, 1 bit: high in every state except IDLE.
REQ-011 The block SHALL have port Tx_Done, output, 1 bit: one-cycle pulse at the end of each frame.

Function
REQ-012 The block SHALL implement states IDLE, FETCH, LOAD, START, DATA, PARITY and STOP.
REQ-013 IDLE SHALL go to FETCH when Tx_En=1 and Fifo_Status[0]=0; otherwise it stays in IDLE.
REQ-014 FETCH SHALL last 1 cycle with Fifo_Read=1; Fifo_Read SHALL be 0 in every other state and cycle.
REQ-015 LOAD SHALL last 1 cycle and SHALL capture Fifo_Data into an 8-bit shift register on its closing edge, then go to START.
REQ-016 Each of START, DATA, PARITY and STOP SHALL hold each bit for exactly CLKS_PER_BIT cycles, timed by a counter that is cleared on every bit boundary.
REQ-017 Tx SHALL be 0 in START, the data bit in DATA, the parity bit in PARITY, and 1 in STOP, IDLE, FETCH and LOAD.
REQ-018 DATA SHALL send 8 bits LSB first using a 3-bit index running 0..7; after bit 7 it goes to PARITY (PARITY_EN defined) or STOP (not defined).
REQ-019 STOP SHALL last STOP_BITS x CLKS_PER_BIT cycles.
REQ-020 Tx_Done SHALL pulse high for 1 cycle in the final cycle of STOP.
REQ-021 After STOP the block SHALL go to FETCH if Tx_En=1 and empty=0, else to IDLE; the back-to-back idle gap is therefore exactly 2 cycles.
REQ-022 Tx_En falling mid-frame SHALL NOT abort the frame; it only blocks the next start.
REQ-023 Fifo_Status[0] changing after FETCH SHALL have no effect on the current frame.
REQ-024 Fifo_Data changing outside LOAD SHALL have no effect on the current frame.

Reset
REQ-025 Reset=1 SHALL immediately, at any time including mid-frame, force: state IDLE, Tx=1, Fifo_Read=0, Busy=0, Tx_Done=0, counters 0 and shift register 0x00.
REQ-026 After Reset is released, the first FETCH SHALL occur no earlier than the first rising edge with Reset=0.

Configuration
REQ-027 With macro UART_TX_PARITY_EN defined, the PARITY state SHALL be present and SHALL transmit the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
REQ-028 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent, and DATA SHALL go directly to STOP.

Verification
REQ-029 With CLKS_PER_BIT=4, parity off, FIFO holding 0xA5: Tx SHALL read 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles, with a single Fifo_Read pulse and Tx_Done in the last stop cycle.
REQ-030 With UART_TX_PARITY_EN defined, bytes 0xA5 and 0x07 SHALL produce parity bits 0 and 1 respectively, between bit 7 and stop.
REQ-031 With two bytes queued and Tx_En=1: exactly 2 Tx-high cycles SHALL separate the first stop and the second start, and exactly 2 Fifo_Read pulses SHALL occur in total.
REQ-032 With Fifo_Status[0]=1 held for 100 cycles: Fifo_Read SHALL stay 0, Tx SHALL stay 1 and Busy SHALL stay 0.
REQ-033 Reset asserted during DATA bit 3, between clock edges: Tx SHALL be 1 and Busy 0 before the next Clk edge, and after release the next frame SHALL start cleanly from FETCH.
REQ-034 Tx_En dropped during START: the frame SHALL complete with Tx_Done, the block SHALL return to IDLE with empty=0, and no further Fifo_Read SHALL occur.
